// File: rtl/router_pkg.sv
// Shared definitions for the virtual-channel router: default geometry,
// direction route codes and the per-VC state encoding.
package router_pkg;

  localparam int NUM_PORTS_DEF = 6;
  localparam int ADDR_W_DEF    = 3;

  localparam logic [ADDR_W_DEF-1:0] DIR_LOCAL = 3'b000;
  localparam logic [ADDR_W_DEF-1:0] DIR_EAST  = 3'b001;
  localparam logic [ADDR_W_DEF-1:0] DIR_NORTH = 3'b011;
  localparam logic [ADDR_W_DEF-1:0] DIR_WEST  = 3'b010;
  localparam logic [ADDR_W_DEF-1:0] DIR_SOUTH = 3'b110;
  localparam logic [ADDR_W_DEF-1:0] DIR_UP    = 3'b100;

  // Port i's code sits at bits [i*ADDR_W +: ADDR_W]; port 0 is LOCAL.
  localparam logic [NUM_PORTS_DEF*ADDR_W_DEF-1:0] PORT_CODES_DEF =
    {DIR_UP, DIR_SOUTH, DIR_WEST, DIR_NORTH, DIR_EAST, DIR_LOCAL};

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } vc_state_e;

endpackage

// File: rtl/route_code_match.sv
// Combinational route-code matcher: compares a route code against every
// port code and returns a one-hot enable for the lowest matching port.
module route_code_match #(
  parameter int                          NUM_PORTS  = router_pkg::NUM_PORTS_DEF,
  parameter int                          ADDR_W     = router_pkg::ADDR_W_DEF,
  parameter logic [NUM_PORTS*ADDR_W-1:0] PORT_CODES = router_pkg::PORT_CODES_DEF
) (
  input  logic [ADDR_W-1:0]    route_addr,
  output logic [NUM_PORTS-1:0] onehot,
  output logic                 hit
);

  // Priority match: the first (lowest-index) port whose code equals route_addr wins.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch inferred.
    onehot = '0;
    hit    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!hit && (route_addr == PORT_CODES[i*ADDR_W +: ADDR_W])) begin
        onehot[i] = 1'b1;
        hit       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/route_port_decoder.sv
// Registered route decoder: decodes head flits into a one-hot output-port
// enable, holds it per virtual channel until the tail, and flags illegal
// codes and protocol errors with a saturating error counter.
module route_port_decoder
  import router_pkg::*;
#(
  parameter int                          NUM_PORTS  = NUM_PORTS_DEF,
  parameter int                          ADDR_W     = ADDR_W_DEF,
  parameter logic [NUM_PORTS*ADDR_W-1:0] PORT_CODES = PORT_CODES_DEF,
  parameter int                          NUM_VC     = 2,
  parameter int                          VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flit_valid,
  output logic                 flit_ready,
  input  logic [VC_W-1:0]      flit_vc,
  input  logic                 flit_head,
  input  logic                 flit_tail,
  input  logic [ADDR_W-1:0]    route_addr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_PORTS-1:0] out_en,
  output logic [VC_W-1:0]      out_vc,
  output logic                 route_err,
  output logic [7:0]           err_count,
  output logic [NUM_VC-1:0]    vc_busy
);

  vc_state_e              state_q [NUM_VC];
  logic [NUM_PORTS-1:0]   held_q  [NUM_VC];

  logic                   out_valid_q;
  logic [NUM_PORTS-1:0]   out_en_q;
  logic [VC_W-1:0]        out_vc_q;
  logic                   route_err_q;
  logic [7:0]             err_count_q;

  logic [NUM_PORTS-1:0]   dec_onehot;
  logic                   dec_hit;
  logic                   accept;

  vc_state_e              cur_state;
  logic [NUM_PORTS-1:0]   cur_held;
  vc_state_e              state_d;
  logic [NUM_PORTS-1:0]   held_d;
  logic [NUM_PORTS-1:0]   out_en_d;
  logic                   route_err_d;

  route_code_match #(
    .NUM_PORTS  (NUM_PORTS),
    .ADDR_W     (ADDR_W),
    .PORT_CODES (PORT_CODES)
  ) u_match (
    .route_addr (route_addr),
    .onehot     (dec_onehot),
    .hit        (dec_hit)
  );

  assign flit_ready = !out_valid_q || out_ready;
  assign accept     = flit_valid && flit_ready;

  // Select the addressed VC's state and held route.
  always_comb begin
    cur_state = IDLE;
    cur_held  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (VC_W'(v) == flit_vc) begin
        cur_state = state_q[v];
        cur_held  = held_q[v];
      end
    end
  end

  // Next VC state and output beat for the presented flit. An abandoned head
  // that also misses counts as a single erroneous beat.
  always_comb begin
    state_d     = cur_state;
    held_d      = cur_held;
    out_en_d    = '0;
    route_err_d = 1'b0;
    if (flit_head) begin
      out_en_d    = dec_onehot;
      route_err_d = !dec_hit || (cur_state == ACTIVE);
      if (dec_hit && !flit_tail) begin
        state_d = ACTIVE;
        held_d  = dec_onehot;
      end else begin
        state_d = IDLE;
        held_d  = '0;
      end
    end else if (cur_state == ACTIVE) begin
      out_en_d = cur_held;
      if (flit_tail) begin
        state_d = IDLE;
        held_d  = '0;
      end
    end else begin
      route_err_d = 1'b1;
    end
  end

  // Per-VC state; only the addressed VC moves, and only on an accepted flit.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the held-route array is reset explicitly because a reset must drop every in-flight route.
      for (int v = 0; v < NUM_VC; v++) begin
        state_q[v] <= IDLE;
        held_q[v]  <= '0;
      end
    end else if (accept) begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (VC_W'(v) == flit_vc) begin
          state_q[v] <= state_d;
          held_q[v]  <= held_d;
        end
      end
    end
  end

  // Output register: loads on accept, clears once drained, holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      out_valid_q <= 1'b0;
      out_en_q    <= '0;
      out_vc_q    <= '0;
      route_err_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_en_q    <= out_en_d;
      out_vc_q    <= flit_vc;
      route_err_q <= route_err_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
      out_en_q    <= '0;
      out_vc_q    <= '0;
      route_err_q <= 1'b0;
    end
  end

  // Saturating error counter, one step per erroneous accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
    end else if (accept && route_err_d && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  // Busy flags mirror the ACTIVE state of each VC.
  always_comb begin
    vc_busy = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      vc_busy[v] = (state_q[v] == ACTIVE);
    end
  end

  assign out_valid = out_valid_q;
  assign out_en    = out_en_q;
  assign out_vc    = out_vc_q;
  assign route_err = route_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_route_port_decoder.sv
// Directed self-checking bench for route_port_decoder.
module tb_route_port_decoder;

  logic       clk;
  logic       rst;
  logic       flit_valid;
  logic       flit_ready;
  logic [0:0] flit_vc;
  logic       flit_head;
  logic       flit_tail;
  logic [2:0] route_addr;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_en;
  logic [0:0] out_vc;
  logic       route_err;
  logic [7:0] err_count;
  logic [1:0] vc_busy;

  int n_tests;
  int n_fail;

  route_port_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .flit_valid (flit_valid),
    .flit_ready (flit_ready),
    .flit_vc    (flit_vc),
    .flit_head  (flit_head),
    .flit_tail  (flit_tail),
    .route_addr (route_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_en     (out_en),
    .out_vc     (out_vc),
    .route_err  (route_err),
    .err_count  (err_count),
    .vc_busy    (vc_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [0:0] vc, input logic h,
                       input logic t, input logic [2:0] a);
    flit_valid = v;
    flit_vc    = vc;
    flit_head  = h;
    flit_tail  = t;
    route_addr = a;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, out_en, out_vc, route_err, err_count, vc_busy, flit_ready} !==
        {1'b0, 6'b0, 1'b0, 1'b0, 8'd0, 2'b00, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: got v=%b en=%b vc=%b err=%b cnt=%0d busy=%b rdy=%b, want all zero, rdy=1",
               out_valid, out_en, out_vc, route_err, err_count, vc_busy, flit_ready);
    end
  endtask

  task automatic test_packet;
    logic [2:0] kind [3];
    logic [1:0] busy_exp [3];
    kind[0] = 3'b010; kind[1] = 3'b000; kind[2] = 3'b001;   // {head, tail} encoded as {h,t} in bits [1:0]
    busy_exp[0] = 2'b01; busy_exp[1] = 2'b01; busy_exp[2] = 2'b00;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, kind[i][1], kind[i][0], (i == 0) ? 3'b011 : 3'b111);
      if (i == 0) begin
        n_tests++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL pkt_latency: out_valid=%b before accept edge, want 0", out_valid);
        end
      end
      tick();
      n_tests++;
      if ({out_valid, out_en, out_vc, route_err, vc_busy} !== {1'b1, 6'b000100, 1'b0, 1'b0, busy_exp[i]}) begin
        n_fail++;
        $display("FAIL pkt_beat%0d: got v=%b en=%b vc=%b err=%b busy=%b, want v=1 en=000100 vc=0 err=0 busy=%b",
                 i, out_valid, out_en, out_vc, route_err, vc_busy, busy_exp[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pkt_drain: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_interleave;
    logic [0:0] vc_s [6];
    logic       hd_s [6];
    logic       tl_s [6];
    logic [2:0] ad_s [6];
    logic [5:0] en_e [6];
    logic [1:0] bz_e [6];
    vc_s = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    hd_s = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tl_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ad_s = '{3'b110, 3'b000, 3'b111, 3'b111, 3'b111, 3'b111};
    en_e = '{6'b010000, 6'b000001, 6'b010000, 6'b000001, 6'b010000, 6'b000001};
    bz_e = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vc_s[i], hd_s[i], tl_s[i], ad_s[i]);
      tick();
      n_tests++;
      if ({out_valid, out_en, out_vc, route_err, vc_busy} !== {1'b1, en_e[i], vc_s[i], 1'b0, bz_e[i]}) begin
        n_fail++;
        $display("FAIL interleave%0d: got v=%b en=%b vc=%b err=%b busy=%b, want v=1 en=%b vc=%b err=0 busy=%b",
                 i, out_valid, out_en, out_vc, route_err, vc_busy, en_e[i], vc_s[i], bz_e[i]);
      end
    end
  endtask

  task automatic test_illegal;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b111);
    tick();
    n_tests++;
    if ({out_valid, out_en, route_err, err_count, vc_busy} !== {1'b1, 6'b0, 1'b1, 8'd1, 2'b00}) begin
      n_fail++;
      $display("FAIL illegal_111: got v=%b en=%b err=%b cnt=%0d busy=%b, want v=1 en=0 err=1 cnt=1 busy=00",
               out_valid, out_en, route_err, err_count, vc_busy);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b101);
    tick();
    n_tests++;
    if ({out_en, route_err, err_count, vc_busy} !== {6'b0, 1'b1, 8'd2, 2'b00}) begin
      n_fail++;
      $display("FAIL illegal_101: got en=%b err=%b cnt=%0d busy=%b, want en=0 err=1 cnt=2 busy=00",
               out_en, route_err, err_count, vc_busy);
    end
  endtask

  task automatic test_body_on_idle;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
    tick();
    n_tests++;
    if ({out_valid, out_en, out_vc, route_err, err_count} !== {1'b1, 6'b0, 1'b1, 1'b1, 8'd3}) begin
      n_fail++;
      $display("FAIL idle_body: got v=%b en=%b vc=%b err=%b cnt=%0d, want v=1 en=0 vc=1 err=1 cnt=3",
               out_valid, out_en, out_vc, route_err, err_count);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b001);
    tick();
    n_tests++;
    if ({out_en, out_vc, route_err, err_count, vc_busy} !== {6'b000010, 1'b1, 1'b0, 8'd3, 2'b00}) begin
      n_fail++;
      $display("FAIL single_flit: got en=%b vc=%b err=%b cnt=%0d busy=%b, want en=000010 vc=1 err=0 cnt=3 busy=00",
               out_en, out_vc, route_err, err_count, vc_busy);
    end
  endtask

  task automatic test_back_to_back_stall;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b010);
    tick();
    n_tests++;
    if ({out_en, out_vc, vc_busy} !== {6'b001000, 1'b0, 2'b01}) begin
      n_fail++;
      $display("FAIL stall_head: got en=%b vc=%b busy=%b, want en=001000 vc=0 busy=01", out_en, out_vc, vc_busy);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b110);
    tick();
    n_tests++;
    if ({out_en, out_vc} !== {6'b010000, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_single: got en=%b vc=%b, want en=010000 vc=1", out_en, out_vc);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b111);
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({flit_ready, out_valid, out_en, out_vc, vc_busy} !== {1'b0, 1'b1, 6'b010000, 1'b1, 2'b01}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got rdy=%b v=%b en=%b vc=%b busy=%b, want rdy=0 v=1 en=010000 vc=1 busy=01",
                 i, flit_ready, out_valid, out_en, out_vc, vc_busy);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if ({flit_ready, out_en, out_vc} !== {1'b1, 6'b010000, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_release: got rdy=%b en=%b vc=%b, want rdy=1 en=010000 vc=1", flit_ready, out_en, out_vc);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    n_tests++;
    if ({out_valid, out_en, out_vc, route_err, vc_busy} !== {1'b1, 6'b001000, 1'b0, 1'b0, 2'b00}) begin
      n_fail++;
      $display("FAIL stall_tail: got v=%b en=%b vc=%b err=%b busy=%b, want v=1 en=001000 vc=0 err=0 busy=00",
               out_valid, out_en, out_vc, route_err, vc_busy);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_nodup: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_packet;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b011);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    tick();
    rst = 1'b0;
    n_tests++;
    if ({out_valid, out_en, out_vc, route_err, err_count, vc_busy} !== {1'b0, 6'b0, 1'b0, 1'b0, 8'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL midreset: got v=%b en=%b vc=%b err=%b cnt=%0d busy=%b, want all zero",
               out_valid, out_en, out_vc, route_err, err_count, vc_busy);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b011);
    tick();
    n_tests++;
    if ({out_valid, out_en, route_err, err_count} !== {1'b1, 6'b0, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL midreset_body: got v=%b en=%b err=%b cnt=%0d, want v=1 en=0 err=1 cnt=1",
               out_valid, out_en, route_err, err_count);
    end
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b111);
      tick();
      if (i == 252) begin
        n_tests++;
        if (err_count !== 8'd254) begin
          n_fail++;
          $display("FAIL sat_254: err_count=%0d, want 254", err_count);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    n_tests++;
    if (err_count !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_255: err_count=%0d, want 255", err_count);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    test_reset();
    test_packet();
    test_interleave();
    test_illegal();
    test_body_on_idle();
    test_back_to_back_stall();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/route_port_decoder.md
Name: route_port_decoder

Overview:
- Parametrised, registered successor to the six-output port decoder in the virtual channel router.
- Decodes the route field of a head flit into a one-hot output-port enable and holds that enable per virtual channel until the tail flit.
- Body and tail flits inherit the route without re-decoding.
- Sits between input-VC buffers and the switch allocator. Adds a valid/ready handshake, illegal-code detection and an error counter.

Parameters:
- NUM_PORTS, 6, number of output ports / width of the one-hot enable.
- ADDR_W, 3, width of the route code.
- PORT_CODES, {3'b100,3'b110,3'b010,3'b011,3'b001,3'b000}, concatenated route codes; port i's code occupies bits [i*ADDR_W +: ADDR_W].
- NUM_VC, 2, virtual channels tracked.
- VC_W, 1, clog2(NUM_VC), minimum 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flit_valid  in  1  input flit present.
- flit_ready  out  1  block can accept a flit.
- flit_vc  in  VC_W  VC of the input flit.
- flit_head  in  1  flit is a head.
- flit_tail  in  1  flit is a tail; head and tail both high means a single-flit packet.
- route_addr  in  ADDR_W  route code; sampled on head flits only.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  downstream accepts the result.
- out_en  out  NUM_PORTS  one-hot port enable; all-zero means drop.
- out_vc  out  VC_W  VC of the result.
- route_err  out  1  result carries an error; qualified by out_valid.
- err_count  out  8  saturating error count.
- vc_busy  out  NUM_VC  bit v high while VC v holds a route.

Behaviour:
- Reset: clocked with rst=1, synchronous. Afterwards out_valid=0, out_en=0, out_vc=0, route_err=0, err_count=0, vc_busy=0, every VC in IDLE with held route 0. Reset mid-packet discards the in-flight output and all held routes; no tail is required afterwards.
- Handshake: flit_ready = !out_valid || out_ready, combinational. Input accepted when flit_valid && flit_ready. Output consumed when out_valid && out_ready. Output holds stable while out_valid && !out_ready.
- Latency: exactly 1 cycle from accept to out_valid. Full throughput of 1 flit/cycle when out_ready=1.
- Per-VC FSM: states IDLE and ACTIVE; held[v] is NUM_PORTS bits.
- Code match: compare route_addr with every PORT_CODES entry. The lowest matching index wins, giving hit=1 and a one-hot vector. No match gives hit=0 and a zero vector.
- IDLE, head with hit: out_en=onehot, route_err=0. If tail=0, go to ACTIVE and latch held[v]=onehot. If tail=1, stay IDLE.
- IDLE, head without hit: out_en=0, route_err=1, err_count+1, stay IDLE.
- IDLE, non-head: protocol error. out_en=0, route_err=1, err_count+1, stay IDLE.
- ACTIVE, non-head: out_en=held[v], route_err=0; route_addr is ignored. tail=1 returns to IDLE and clears held[v].
- ACTIVE, head: abandoned packet. route_err=1 and err_count+1, then the flit is treated exactly as the IDLE head case: re-decode, and out_en follows the new decode.
- Errors: route_err is registered with the output and reads 1 only on the erroneous output beat. err_count saturates at 255, never wraps, and is cleared only by rst.
- vc_busy[v] reflects state ACTIVE and updates on the accept edge.
- State updates happen only on accepted flits; a stalled output freezes all VC state.

Decomposition:
- Package router_pkg holds:
  - default NUM_PORTS/ADDR_W;
  - direction code constants DIR_LOCAL=000, DIR_EAST=001, DIR_NORTH=011, DIR_WEST=010, DIR_SOUTH=110, DIR_UP=100;
  - VC state encoding IDLE=0, ACTIVE=1.
- One combinational sub-module, route_code_match (route_addr, PORT_CODES → onehot, hit), reused by the allocator.
- The top module holds the per-VC state array, the output register and the error counter.

Test Plan:
- After reset, on VC0 send head route_addr=011, body, then tail, with out_ready=1. Expect out_en=000100 on three consecutive beats, 1-cycle latency, vc_busy=01 during the packet and 00 after the tail.
- Interleave VC0 head 110 and VC1 head 000, then alternate body flits with route_addr=111. Expect VC0 beats 010000 and VC1 beats 000001; the body route_addr is ignored.
- Send a head with route_addr=111 or 101. Expect out_en=000000, route_err=1, err_count=1, and the VC stays IDLE.
- On IDLE VC1, send a body flit, then a single-flit head+tail 001. Expect first out_en=0 with route_err=1, then out_en=000010 with route_err=0 and vc_busy[1]=0.
- Hold out_ready=0 for 4 cycles with flit_valid=1. Expect flit_ready=0 and out_en/out_vc stable. Release out_ready: the buffered flit drains first, with no flit lost or duplicated.
- Mid-packet on VC0, assert rst for 1 cycle. Expect all outputs 0 and vc_busy=0. A following body flit on VC0 gives route_err=1. 300 illegal heads give err_count=255.
